div16s_seq: RTL and testbench



---
 rtl/div_pkg.sv | 23 ++
 rtl/div_restore_step.sv | 26 ++
 rtl/div16s_seq.sv | 191 +++++++++++++++++++
 tb/tb_div16s_seq.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider.
//   DIV_W   : default operand / quotient / remainder width
//   state_t : controller states
//   QMAX    : positive saturation value of the quotient
//   QMIN    : negative saturation value of the quotient
//   CNT_W   : width of the iteration counter (counts 2*DIV_W steps)
package div_pkg;

  localparam int DIV_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [DIV_W-1:0] QMAX = 8'h7F;
  localparam logic [DIV_W-1:0] QMIN = 8'h80;

  localparam int CNT_W = $clog2(2 * DIV_W);

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration, purely combinational.
// Ports:
//   rem_in  : partial remainder before the step (always < dvs)
//   bit_in  : next dividend bit, shifted into the remainder LSB
//   dvs     : divisor magnitude (W+1 bits so that 2^(W-1) is representable)
//   rem_out : partial remainder after the step
//   q_bit   : quotient bit produced by the step
module div_restore_step #(
  parameter int W = 8
) (
  input  logic [W:0] rem_in,
  input  logic       bit_in,
  input  logic [W:0] dvs,
  output logic [W:0] rem_out,
  output logic       q_bit
);

  // The shifted remainder is below 2*dvs, so the trial difference lies in
  // [-dvs, dvs) and one extra sign bit is enough to hold it.
  logic signed [W+1:0] diff;

  assign diff    = signed'({rem_in, bit_in}) - signed'({1'b0, dvs});
  assign q_bit   = (diff >= 0);
  assign rem_out = q_bit ? diff[W:0] : {rem_in[W-1:0], bit_in};

endmodule

// File: rtl/div16s_seq.sv
// Sequential signed divider: 2*W-bit signed dividend by W-bit signed divisor,
// restoring division on magnitudes, one quotient bit per clock.
// Optional build macro: DIV_APPROX_EN -- clears the low APPROX_LSBS bits of
// the dividend magnitude before dividing (mirrors the approximate multiplier).
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   in_valid    : operands valid          in_ready  : idle, operands accepted
//   A           : dividend (2*W, signed)  B         : divisor (W, signed)
//   out_valid   : result valid            out_ready : consumer takes result
//   Q, R        : quotient / remainder (W, signed)
//   ovf         : quotient saturated      dz        : divide by zero
module div16s_seq
  import div_pkg::*;
#(
  parameter int W = DIV_W
`ifdef DIV_APPROX_EN
  ,
  parameter int APPROX_LSBS = 4
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*W-1:0]   A,
  input  logic [W-1:0]     B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     Q,
  output logic [W-1:0]     R,
  output logic             ovf,
  output logic             dz
);

  localparam int DW = 2 * W;
  localparam int CW = (W == DIV_W) ? CNT_W : $clog2(2 * W);

  localparam logic [W-1:0] SAT_POS = (W == DIV_W) ? W'(QMAX) : {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SAT_NEG = (W == DIV_W) ? W'(QMIN) : {1'b1, {(W-1){1'b0}}};

  // Largest quotient magnitudes that still fit for each result sign.
  localparam logic [DW:0] QPOS_LIM = (DW+1)'((1 << (W-1)) - 1);
  localparam logic [DW:0] QNEG_LIM = (DW+1)'(1 << (W-1));

`ifdef DIV_APPROX_EN
  localparam logic [DW:0] APPROX_MASK = ~((DW+1)'((1 << APPROX_LSBS) - 1));
`endif

  function automatic logic [W-1:0] sat_q(input logic neg);
    return neg ? SAT_NEG : SAT_POS;
  endfunction

  function automatic logic [W-1:0] apply_sign(input logic [W-1:0] mag, input logic neg);
    return neg ? (~mag + 1'b1) : mag;
  endfunction

  state_t state, state_nxt;

  logic [CW-1:0] cnt;
  logic [DW-1:0] dvd_sh;   // remaining dividend bits, MSB first
  logic [DW-1:0] quo_lo;   // quotient bits produced by the CALC steps
  logic          quo_hi;   // quotient bit 2*W, resolved at capture
  logic [W:0]    rem;
  logic [W:0]    b_mag;
  logic          q_neg;
  logic          r_neg;

  logic [W-1:0]  q_r;
  logic [W-1:0]  r_r;
  logic          ovf_r;
  logic          dz_r;

  logic               accept;
  logic signed [DW:0] a_ext;
  logic [DW:0]        a_mag;
  logic [DW:0]        a_mag_eff;
  logic signed [W:0]  b_ext;
  logic [W:0]         b_mag_c;
  logic               b_zero;
  logic               top_fit;
  logic [W:0]         rem_init;
  logic [W:0]         rem_nxt;
  logic               q_bit;
  logic [DW:0]        q_mag;
  logic               q_ovf;

  assign accept = in_valid && in_ready;

  // Magnitudes are one bit wider than the operands so that the most
  // negative inputs (-2^(2W-1), -2^(W-1)) do not wrap.
  assign a_ext   = {A[DW-1], A};
  assign a_mag   = A[DW-1] ? -a_ext : a_ext;
  assign b_ext   = {B[W-1], B};
  assign b_mag_c = B[W-1] ? -b_ext : b_ext;
  assign b_zero  = (B == '0);

`ifdef DIV_APPROX_EN
  assign a_mag_eff = a_mag & APPROX_MASK;
`else
  assign a_mag_eff = a_mag;
`endif

  // Only 2*W steps run, so the magnitude's top bit (set only for -2^(2W-1))
  // is divided at capture: it yields a quotient bit exactly when |B| == 1,
  // otherwise it simply seeds the partial remainder.
  assign top_fit  = a_mag_eff[DW] && (b_mag_c == (W+1)'(1));
  assign rem_init = {{W{1'b0}}, a_mag_eff[DW] && !top_fit};

  div_restore_step #(.W(W)) u_step (
    .rem_in  (rem),
    .bit_in  (dvd_sh[DW-1]),
    .dvs     (b_mag),
    .rem_out (rem_nxt),
    .q_bit   (q_bit)
  );

  assign q_mag = {quo_hi, quo_lo};
  assign q_ovf = q_neg ? (q_mag > QNEG_LIM) : (q_mag > QPOS_LIM);

  // Controller
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = b_zero ? DONE : CALC;
      CALC: if (cnt == '0) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);

  // Working registers: capture in IDLE, one restoring step per CALC cycle
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (accept) begin
          dvd_sh <= a_mag_eff[DW-1:0];
          quo_hi <= top_fit;
          quo_lo <= '0;
          rem    <= rem_init;
          b_mag  <= b_mag_c;
          q_neg  <= A[DW-1] ^ B[W-1];
          r_neg  <= A[DW-1];
          cnt    <= CW'(DW - 1);
        end
      end
      CALC: begin
        rem    <= rem_nxt;
        dvd_sh <= {dvd_sh[DW-2:0], 1'b0};
        quo_lo <= {quo_lo[DW-2:0], q_bit};
        cnt    <= cnt - 1'b1;
      end
      default: ;
    endcase
  end

  // Result registers: divide-by-zero resolves at capture, normal results in FIX
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r   <= '0;
      r_r   <= '0;
      ovf_r <= 1'b0;
      dz_r  <= 1'b0;
    end else if (state == IDLE && accept && b_zero) begin
      q_r   <= sat_q(A[DW-1]);
      r_r   <= A[W-1:0];
      ovf_r <= 1'b0;
      dz_r  <= 1'b1;
    end else if (state == FIX) begin
      q_r   <= q_ovf ? sat_q(q_neg) : apply_sign(quo_lo[W-1:0], q_neg);
      // rem < |B| <= 2^(W-1), so its magnitude always fits in W bits
      r_r   <= apply_sign(rem[W-1:0], r_neg);
      ovf_r <= q_ovf;
      dz_r  <= 1'b0;
    end
  end

  assign Q   = q_r;
  assign R   = r_r;
  assign ovf = ovf_r;
  assign dz  = dz_r;

endmodule

// File: tb/tb_div16s_seq.sv
// Self-checking bench for div16s_seq: directed cases, hold/reset behaviour
// and randomized operands checked against an integer-arithmetic model.
module tb_div16s_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [7:0]  B;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  Q;
  logic [7:0]  R;
  logic        ovf;
  logic        dz;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  div16s_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Q         (Q),
    .R         (R),
    .ovf       (ovf),
    .dz        (dz)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference: signed integer division truncating toward zero, then saturation.
  task automatic ref_div(input logic [15:0] a, input logic [7:0] b,
                         output logic [7:0] q, output logic [7:0] r,
                         output logic o, output logic z);
    int ai, bi, qi, ri;
    ai = int'($signed(a));
    bi = int'($signed(b));
    if (bi == 0) begin
      z = 1'b1;
      o = 1'b0;
      q = (ai >= 0) ? 8'h7F : 8'h80;
      r = a[7:0];
      return;
    end
`ifdef DIV_APPROX_EN
    begin
      int m;
      m  = (ai < 0 ? -ai : ai) & ~15;
      ai = (ai < 0) ? -m : m;
    end
`endif
    qi = ai / bi;
    ri = ai % bi;
    z  = 1'b0;
    o  = 1'b0;
    if (qi > 127) begin
      qi = 127;
      o  = 1'b1;
    end else if (qi < -128) begin
      qi = -128;
      o  = 1'b1;
    end
    q = 8'(qi);
    r = 8'(ri);
  endtask

  task automatic do_op(input logic [15:0] a, input logic [7:0] b,
                       input logic [7:0] eq, input logic [7:0] er,
                       input logic eo, input logic ez, input string tag);
    int edges;
    @(negedge clk);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    A         = a;
    B         = b;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    edges    = 1;
    while (!out_valid && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
    chk({tag, ".latency"}, 32'(edges), ez ? 32'd1 : 32'd18);
    chk({tag, ".Q"},   32'(Q),   32'(eq));
    chk({tag, ".R"},   32'(R),   32'(er));
    chk({tag, ".ovf"}, 32'(ovf), 32'(eo));
    chk({tag, ".dz"},  32'(dz),  32'(ez));
    @(posedge clk);
    #1;
    chk({tag, ".out_valid_clr"}, 32'(out_valid), 32'd0);
    chk({tag, ".in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  task automatic do_ref(input logic [15:0] a, input logic [7:0] b, input string tag);
    logic [7:0] eq, er;
    logic       eo, ez;
    ref_div(a, b, eq, er, eo, ez);
    do_op(a, b, eq, er, eo, ez, tag);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra;
    logic [7:0]  rb;
    int          edges;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = '0;
    B         = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.in_ready",  32'(in_ready),  32'd0);
    chk("rst.Q",   32'(Q),   32'd0);
    chk("rst.R",   32'(R),   32'd0);
    chk("rst.ovf", 32'(ovf), 32'd0);
    chk("rst.dz",  32'(dz),  32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
`ifdef DIV_APPROX_EN
    do_op(16'd100,   8'd7,         8'd13, 8'd5,  1'b0, 1'b0, "p100_7");
    do_op(-16'sd100, 8'd7,         8'hF3, 8'hFB, 1'b0, 1'b0, "m100_7");
    do_op(16'd100,   -8'sd7,       8'hF3, 8'd5,  1'b0, 1'b0, "p100_m7");
    do_op(16'd1000,  8'd3,         8'h7F, 8'd2,  1'b1, 1'b0, "ovf_1000_3");
    do_op(16'd1000,  8'd100,       8'd9,  8'd92, 1'b0, 1'b0, "approx_1000_100");
`else
    do_op(16'd100,   8'd7,         8'd14, 8'd2,  1'b0, 1'b0, "p100_7");
    do_op(-16'sd100, 8'd7,         8'hF2, 8'hFE, 1'b0, 1'b0, "m100_7");
    do_op(16'd100,   -8'sd7,       8'hF2, 8'd2,  1'b0, 1'b0, "p100_m7");
    do_op(16'd1000,  8'd3,         8'h7F, 8'd1,  1'b1, 1'b0, "ovf_1000_3");
    do_op(16'd1000,  8'd100,       8'd10, 8'd0,  1'b0, 1'b0, "exact_1000_100");
`endif
    do_op(-16'sd128,   8'd1,       8'h80, 8'd0,  1'b0, 1'b0, "m128_1");
    do_op(16'h8000,    8'hFF,      8'h7F, 8'd0,  1'b1, 1'b0, "min_m1");
    do_op(16'h8000,    8'd1,       8'h80, 8'd0,  1'b1, 1'b0, "min_1");
    do_op(-16'sd16384, 8'h80,      8'h7F, 8'd0,  1'b1, 1'b0, "m16384_m128");
    do_op(16'd5,       8'd0,       8'h7F, 8'd5,  1'b0, 1'b1, "dz_p5");
    do_op(-16'sd5,     8'd0,       8'h80, 8'hFB, 1'b0, 1'b1, "dz_m5");
    do_ref(16'h8000,   8'h80, "min_m128");
    do_ref(16'h7FFF,   8'h80, "max_m128");

    // Hold: result stays put while out_ready is low, new operands ignored
    @(negedge clk);
    A         = 16'd1000;
    B         = 8'd3;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    edges    = 1;
    while (!out_valid && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
    chk("hold.latency", 32'(edges), 32'd18);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      A        = 16'd7;
      B        = 8'd1;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("hold.out_valid", 32'(out_valid), 32'd1);
      chk("hold.in_ready",  32'(in_ready),  32'd0);
      chk("hold.Q",   32'(Q),   32'h7F);
`ifdef DIV_APPROX_EN
      chk("hold.R",   32'(R),   32'd2);
`else
      chk("hold.R",   32'(R),   32'd1);
`endif
      chk("hold.ovf", 32'(ovf), 32'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hold.release_valid", 32'(out_valid), 32'd0);
    chk("hold.release_ready", 32'(in_ready),  32'd1);

    // Reset in the middle of CALC discards the operation
    @(negedge clk);
    A        = 16'd100;
    B        = 8'd7;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst.out_valid", 32'(out_valid), 32'd0);
    chk("midrst.in_ready",  32'(in_ready),  32'd0);
    chk("midrst.Q",   32'(Q),   32'd0);
    chk("midrst.R",   32'(R),   32'd0);
    chk("midrst.ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst.in_ready_rel", 32'(in_ready), 32'd1);
    repeat (12) @(posedge clk);
    #1;
    chk("midrst.no_output", 32'(out_valid), 32'd0);
    do_ref(16'd100, 8'd7, "after_rst");

    // Randomized operands against the reference model
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: ra = 16'($urandom);
        1: ra = 16'($signed(8'($urandom)) * $signed(8'($urandom)));
        2: ra = 16'($signed(8'($urandom)));
        default: ra = ($urandom_range(0, 1) == 0) ? 16'h8000 : 16'h7FFF;
      endcase
      case ($urandom_range(0, 7))
        0: rb = 8'd0;
        1: rb = 8'h80;
        2: rb = ($urandom_range(0, 1) == 0) ? 8'd1 : 8'hFF;
        default: rb = 8'($urandom);
      endcase
      do_ref(ra, rb, $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
